wb_select_pipe: RTL and testbench

Parametrised, registered successor to the combinational write-back select. It picks the write-back value from N_SRC execute-side sources (ALU result, next PC, etc.) or from a variable-latency load return. It registers the chosen value with its destination register and write enable, and presents it to the register file over a valid/ready handshake. It sits between the execute/memory stage and the register-file write port.

---
 rtl/kgp_pkg.sv | 17 +
 rtl/wb_src_mux.sv | 22 ++
 rtl/wb_select_pipe.sv | 112 +++++++++++
 tb/tb_wb_select_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared definitions for the write-back select pipe: default widths, select
// encodings and the load-wait state enum.
package kgp_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned REG_AW_DEF = 5;

   localparam logic [1:0] MTR_ALU  = 2'd0;
   localparam logic [1:0] MTR_PC   = 2'd1;
   localparam logic [1:0] MTR_LOAD = 2'd2;

   typedef enum logic [0:0] {
      StRun      = 1'b0,
      StWaitLoad = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// N_SRC-way combinational source selector; any select code without a matching
// source falls back to source 0.
module wb_src_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_SRC  = 3,
   parameter int unsigned SEL_W  = 2
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   output logic [DATA_W-1:0]       data
);

   always_comb begin
      data = src_data[DATA_W-1:0];
      for (int unsigned k = 1; k < N_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            data = src_data[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/wb_select_pipe.sv
// Registered write-back select: picks an execute-side source or waits for a load
// return, then holds the result for the register file behind a valid/ready handshake.
module wb_select_pipe
   import kgp_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned N_SRC      = 3,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned LOAD_SEL   = MTR_LOAD,
   parameter int unsigned REG_AW     = REG_AW_DEF,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned ZERO_GUARD = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W-1:0]        mem_to_reg,
   input  logic [N_SRC*DATA_W-1:0] src_data,
   input  logic [REG_AW-1:0]       rd_addr,
   input  logic                    reg_write,
   input  logic                    mem_rvalid,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [DATA_W-1:0]       wb_data,
   output logic [REG_AW-1:0]       wb_addr,
   output logic                    wb_we,
   output logic                    timeout_err,
   output logic                    spurious_err
);

   localparam int unsigned CntW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit          TimeoutEn = (TIMEOUT > 0);
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   wb_state_e         state_q;
   logic [CntW-1:0]   wait_cnt_q;
   logic              accept;
   logic              is_load;
   logic              guard_we;
   logic [DATA_W-1:0] mux_data;

   wb_src_mux #(
      .DATA_W (DATA_W),
      .N_SRC  (N_SRC),
      .SEL_W  (SEL_W)
   ) u_src_mux (
      .sel      (mem_to_reg),
      .src_data (src_data),
      .data     (mux_data)
   );

   assign in_ready = (state_q == StRun) && (!wb_valid || wb_ready);
   assign accept   = in_valid && in_ready;
   assign is_load  = (mem_to_reg == SEL_W'(LOAD_SEL));
   assign guard_we = reg_write && !((ZERO_GUARD != 0) && (rd_addr == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StRun;
         wait_cnt_q   <= '0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_addr      <= '0;
         wb_we        <= 1'b0;
         timeout_err  <= 1'b0;
         spurious_err <= 1'b0;
      end else begin
         timeout_err  <= 1'b0;
         spurious_err <= 1'b0;
         unique case (state_q)
            StRun: begin
               if (mem_rvalid) begin
                  spurious_err <= 1'b1;
               end
               if (accept) begin
                  wb_addr <= rd_addr;
                  wb_we   <= guard_we;
                  if (is_load) begin
                     wb_valid   <= 1'b0;
                     wait_cnt_q <= '0;
                     state_q    <= StWaitLoad;
                  end else begin
                     wb_valid <= 1'b1;
                     wb_data  <= mux_data;
                  end
               end else if (wb_ready) begin
                  wb_valid <= 1'b0;
               end
            end
            StWaitLoad: begin
               wait_cnt_q <= wait_cnt_q + CntW'(1);
               // Returned data takes priority over a timeout in the same cycle.
               if (mem_rvalid) begin
                  wb_data  <= mem_rdata;
                  wb_valid <= 1'b1;
                  state_q  <= StRun;
               end else if (TimeoutEn && (wait_cnt_q == CntLast)) begin
                  wb_data     <= '0;
                  wb_we       <= 1'b0;
                  wb_valid    <= 1'b1;
                  timeout_err <= 1'b1;
                  state_q     <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench for wb_select_pipe: directed scenarios plus randomized traffic.
module tb_wb_select_pipe;
   import kgp_pkg::*;

   localparam int unsigned TO = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid, in_ready;
   logic [1:0]  mem_to_reg;
   logic [95:0] src_data;
   logic [4:0]  rd_addr;
   logic        reg_write;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid, wb_ready, wb_we;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic        timeout_err, spurious_err;

   logic [31:0] src [3];
   assign src_data = {src[2], src[1], src[0]};

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int checks = 0, failures = 0;
   int exp_tmo = 0, exp_spur = 0, seen_tmo = 0, seen_spur = 0;
   int ready_mode = 1;

   wb_select_pipe u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mem_to_reg   (mem_to_reg),
      .src_data     (src_data),
      .rd_addr      (rd_addr),
      .reg_write    (reg_write),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_data      (wb_data),
      .wb_addr      (wb_addr),
      .wb_we        (wb_we),
      .timeout_err  (timeout_err),
      .spurious_err (spurious_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // 0: hold low, 1: hold high, 2: random backpressure
   always begin
      @(posedge clk);
      #2;
      if (ready_mode == 2) wb_ready = ($urandom % 4) != 0;
      else wb_ready = (ready_mode == 1);
   end

   always @(negedge clk) begin
      if (rst) begin
         if (timeout_err) seen_tmo++;
         if (spurious_err) seen_spur++;
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               chk("wb_valid_without_expected", 32'(wb_valid), 32'd0);
            end else begin
               chk("wb_data", wb_data, exp_q[0].data);
               chk("wb_addr", 32'(wb_addr), 32'(exp_q[0].addr));
               chk("wb_we", 32'(wb_we), 32'(exp_q[0].we));
               if (wb_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] exp_sel(input logic [1:0] sel);
      if (int'(sel) < 3) return src[sel];
      return src[0];
   endfunction

   task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                        input bit push, input wb_exp_t e, input bit must_ready);
      bit done = 1'b0;
      mem_to_reg = sel;
      rd_addr    = rd;
      reg_write  = we;
      in_valid   = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (must_ready && i == 0) chk("in_ready_immediate", 32'(in_ready), 32'd1);
         if (in_ready) begin
            if (push) exp_q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("accept_wait", 32'(done), 32'd1);
   endtask

   task automatic alu_op(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                         input bit must_ready);
      wb_exp_t e;
      e.data = exp_sel(sel);
      e.addr = rd;
      e.we   = we && (rd != 5'd0);
      issue(sel, rd, we, 1'b1, e, must_ready);
   endtask

   // d = cycles after accept at which the return is sampled; d > TO never returns
   task automatic load_op(input logic [4:0] rd, input logic we, input int d,
                          input logic [31:0] rdata);
      wb_exp_t e;
      bit ret = (d <= int'(TO));
      e.data = ret ? rdata : 32'd0;
      e.addr = rd;
      e.we   = ret && we && (rd != 5'd0);
      issue(MTR_LOAD, rd, we, 1'b1, e, 1'b0);
      for (int i = 1; i < (ret ? d : int'(TO) + 1); i++) begin
         @(negedge clk);
         chk("in_ready_in_wait", 32'(in_ready), 32'd0);
         chk("wb_valid_in_wait", 32'(wb_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      if (ret) begin
         mem_rdata  = rdata;
         mem_rvalid = 1'b1;
         @(negedge clk);
         chk("in_ready_in_wait", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end else begin
         exp_tmo++;
      end
      @(negedge clk);
      chk("load_wb_valid", 32'(wb_valid), 32'd1);
      chk("load_timeout_err", 32'(timeout_err), ret ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("timeout_err_one_cycle", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ready_mode = 1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      wb_exp_t e0;
      e0 = '0;
      in_valid = 1'b0; mem_to_reg = MTR_ALU; rd_addr = '0; reg_write = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      src[0] = '0; src[1] = '0; src[2] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_spurious_err", 32'(spurious_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset during a load wait discards it; the late return is spurious.
      issue(MTR_LOAD, 5'd4, 1'b1, 1'b0, e0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("midload_rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("midload_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      exp_spur++;
      @(negedge clk);
      chk("late_rvalid_spurious", 32'(spurious_err), 32'd1);
      chk("late_rvalid_no_wb", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("spurious_one_cycle", 32'(spurious_err), 32'd0);
      @(posedge clk); #1;
      src[0] = 32'h1234_5678;
      alu_op(MTR_ALU, 5'd9, 1'b1, 1'b1);
      @(negedge clk);
      chk("post_rst_alu_latency", 32'(wb_valid), 32'd1);
      @(posedge clk); #1;

      // ALU then PC, back to back.
      src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
      alu_op(MTR_ALU, 5'd3, 1'b1, 1'b1);
      alu_op(MTR_PC, 5'd31, 1'b1, 1'b1);
      @(negedge clk);
      chk("b2b_second_valid", 32'(wb_valid), 32'd1);
      chk("b2b_second_data", wb_data, 32'h22);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      load_op(5'd7, 1'b1, 4, 32'hDEAD_BEEF);
      load_op(5'd12, 1'b1, 1000, 32'h0);
      load_op(5'd13, 1'b1, int'(TO), 32'hCAFE_F00D);

      // Backpressure: the entry holds for five cycles, then one consume.
      ready_mode = 0;
      src[0] = 32'h55;
      alu_op(MTR_ALU, 5'd5, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_wb_valid", 32'(wb_valid), 32'd1);
         @(posedge clk); #1;
      end
      ready_mode = 1;
      @(negedge clk);
      chk("bp_release_valid", 32'(wb_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_single_consume", 32'(wb_valid), 32'd0);
      @(posedge clk); #1;

      // Register 0 guard and out-of-range select.
      src[0] = 32'hA0A0_0001; src[1] = 32'hB0B0_0002; src[2] = 32'hC0C0_0003;
      alu_op(MTR_ALU, 5'd0, 1'b1, 1'b1);
      @(negedge clk);
      chk("zero_guard_we", 32'(wb_we), 32'd0);
      @(posedge clk); #1;
      alu_op(2'd3, 5'd6, 1'b1, 1'b1);
      @(negedge clk);
      chk("sel3_default_src0", wb_data, src[0]);
      @(posedge clk); #1;

      // Randomized traffic with random backpressure.
      ready_mode = 2;
      for (int n = 0; n < 150; n++) begin
         int unsigned r;
         r = $urandom % 10;
         if (r < 5) begin
            logic [1:0] sel;
            sel = ($urandom % 3 == 2) ? 2'd3 : 2'($urandom % 2);
            src[0] = $urandom; src[1] = $urandom; src[2] = $urandom;
            alu_op(sel, 5'($urandom), 1'($urandom), 1'b0);
         end else if (r < 8) begin
            load_op(5'($urandom), 1'($urandom), int'($urandom_range(1, 18)), $urandom);
         end else if (r == 8) begin
            load_op(5'($urandom), 1'($urandom), int'(TO), $urandom);
         end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            exp_spur++;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
         end
      end

      drain();
      repeat (3) @(posedge clk);
      chk("timeout_err_count", 32'(seen_tmo), 32'(exp_tmo));
      chk("spurious_err_count", 32'(seen_spur), 32'(exp_spur));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
